// File: rtl/mem_initiator.sv
// Valid/ready host initiator for a one-port synchronous memory; all memory-side pins registered.
// Define MEM_INITIATOR_READBACK_EN to verify every write with a readback and flag mismatches on wr_err.
module mem_initiator #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_done,
    output logic              wr_err,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    typedef enum logic [2:0] {
        IDLE, WRITE, READ, RWAIT
`ifdef MEM_INITIATOR_READBACK_EN
        , VREAD, VWAIT
`endif
    } state_t;

    state_t state, state_d;

    logic              ready_d, rw_d, rvld_d, wdone_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d, rdata_d;

`ifdef MEM_INITIATOR_READBACK_EN
    logic err_q, err_d;
    assign wr_err = err_q;
`else
    assign wr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        ready_d = 1'b0;
        rw_d    = 1'b1;
        addr_d  = mem_addr;
        din_d   = mem_datain;
        rvld_d  = 1'b0;
        rdata_d = rsp_rdata;
        wdone_d = 1'b0;
`ifdef MEM_INITIATOR_READBACK_EN
        err_d   = err_q;
`endif
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d = req_addr;
                    if (req_write) begin
                        din_d   = req_wdata;
                        rw_d    = 1'b0;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            WRITE: begin
`ifdef MEM_INITIATOR_READBACK_EN
                state_d = VREAD;
`else
                wdone_d = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
`endif
            end
            READ:  state_d = RWAIT;
            RWAIT: begin
                rdata_d = mem_dataout;
                rvld_d  = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
`ifdef MEM_INITIATOR_READBACK_EN
            VREAD: state_d = VWAIT;
            VWAIT: begin
                // mem_datain still holds the value just written
                if (mem_dataout != mem_datain) err_d = 1'b1;
                wdone_d = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Async reset drives mem_rw high at once so an interrupted write never lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            wr_done    <= 1'b0;
            mem_rw     <= 1'b1;
            mem_addr   <= '0;
            mem_datain <= '0;
        end else begin
            req_ready  <= ready_d;
            rsp_valid  <= rvld_d;
            rsp_rdata  <= rdata_d;
            wr_done    <= wdone_d;
            mem_rw     <= rw_d;
            mem_addr   <= addr_d;
            mem_datain <= din_d;
        end
    end

`ifdef MEM_INITIATOR_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a behavioural one-port memory.
// Honours MEM_INITIATOR_READBACK_EN for write latency and the readback-error sequence.
module tb_mem_initiator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, wr_done, wr_err, mem_rw;
    logic [7:0] rsp_rdata, mem_addr, mem_datain, mem_dout;
    logic       corrupt = 1'b0;

    int tests = 0, failed = 0;
    int cyc = 0;

`ifdef MEM_INITIATOR_READBACK_EN
    localparam int WLAT = 3;
`else
    localparam int WLAT = 1;
`endif

    mem_initiator #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .wr_done(wr_done), .wr_err(wr_err),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_datain(mem_datain),
        .mem_dataout(mem_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-port synchronous memory: write when rw=0, else register read data.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (!mem_rw) mem[mem_addr] <= mem_datain;
        else         mem_dout <= corrupt ? 8'h00 : mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        bit ok;
        wait_ready(ok);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("wr_rw_low", mem_rw, 0);
        chk("wr_addr", mem_addr, a);
        chk("wr_data", mem_datain, d);
        chk("wr_ready_low", req_ready, 0);
        for (int k = 1; k <= WLAT; k++) begin
            @(negedge clk);
            chk("wr_rw_high", mem_rw, 1);
            chk("wr_done_time", wr_done, (k == WLAT));
            chk("wr_rsp_quiet", rsp_valid, 0);
        end
        chk("wr_ready_back", req_ready, 1);
        @(negedge clk);
        chk("wr_done_pulse", wr_done, 0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
        bit ok;
        wait_ready(ok);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 8'hEE;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("rd_rw", mem_rw, 1);
        chk("rd_addr", mem_addr, a);
        chk("rd_early", rsp_valid, 0);
        @(negedge clk);
        chk("rd_early2", rsp_valid, 0);
        @(negedge clk);
        chk("rd_valid", rsp_valid, 1);
        chk("rd_data", rsp_rdata, exp);
        chk("rd_no_wdone", wr_done, 0);
        chk("rd_ready_back", req_ready, 1);
        @(negedge clk);
        chk("rd_pulse", rsp_valid, 0);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;   // write data, or expected read data
    } vec_t;

    vec_t vecs [8];
    logic [7:0] bb_addr [3];
    logic [7:0] bb_data [3];
    int acc [3];

    initial begin
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        vecs[0] = '{1'b1, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 8'h3C, 8'hA5};
        vecs[2] = '{1'b1, 8'h10, 8'h5A};
        vecs[3] = '{1'b1, 8'h10, 8'hC3};
        vecs[4] = '{1'b0, 8'h10, 8'hC3};
        vecs[5] = '{1'b1, 8'hFF, 8'hFF};
        vecs[6] = '{1'b0, 8'hFF, 8'hFF};
        vecs[7] = '{1'b0, 8'h3C, 8'hA5};
        bb_addr[0] = 8'h00; bb_data[0] = 8'h11;
        bb_addr[1] = 8'hFF; bb_data[1] = 8'h22;
        bb_addr[2] = 8'h80; bb_data[2] = 8'h33;

        // Reset with a request already pending
        reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b1;
        req_addr = 8'h3C; req_wdata = 8'h99;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rw", mem_rw, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_datain, 0);
        chk("rst_rvld", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_wdone", wr_done, 0);
        chk("rst_err", wr_err, 0);
        reset_n = 1'b1;
        #1 chk("rel_ready_pre", req_ready, 0);
        @(negedge clk);
        chk("rel_ready_up", req_ready, 1);
        chk("rel_not_accepted", mem_rw, 1);
        req_valid = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].data);
        end
        chk("err_clean", wr_err, 0);

        // Back-to-back writes with req_valid held high
        req_valid = 1'b1; req_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = bb_addr[i]; req_wdata = bb_data[i];
            wait_ready(ok);
            acc[i] = cyc;
            @(posedge clk); @(negedge clk);
            chk("bb_rw", mem_rw, 0);
            chk("bb_addr", mem_addr, bb_addr[i]);
        end
        req_valid = 1'b0;
        chk("bb_gap01", acc[1] - acc[0], WLAT + 1);
        chk("bb_gap12", acc[2] - acc[1], WLAT + 1);
        for (int i = 0; i < 3; i++) do_read(bb_addr[i], bb_data[i]);

        // Reset while in READ
        wait_ready(ok);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h3C;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1 chk("mrd_rw", mem_rw, 1);
        chk("mrd_ready", req_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mrd_no_rsp", rsp_valid, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("mrd_ready_up", req_ready, 1);
        do_read(8'h3C, 8'hA5);

        // Reset while mem_rw is low, before the write edge
        wait_ready(ok);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h3C; req_wdata = 8'h77;
        @(posedge clk);
        #1 chk("mwr_rw_low", mem_rw, 0);
        reset_n = 1'b0;
        #1 chk("mwr_rw_async", mem_rw, 1);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mwr_no_done", wr_done, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        do_read(8'h3C, 8'hA5);

`ifdef MEM_INITIATOR_READBACK_EN
        // Verify read returns a bad value; the write itself lands
        corrupt = 1'b1;
        do_write(8'h40, 8'h5A);
        corrupt = 1'b0;
        chk("err_set", wr_err, 1);
        do_write(8'h41, 8'h12);
        chk("err_sticky", wr_err, 1);
        do_read(8'h40, 8'h5A);
        chk("err_sticky2", wr_err, 1);
`else
        chk("err_tied", wr_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
